// File: rtl/mul_seq_pkg.sv
// Shared encodings and sizes for the shift-and-add multiplier sequencer.
package mul_seq_pkg;

  localparam int W     = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mul_seq_add8.sv
// Combinational ripple-carry adder built from one-bit full-adder cells;
// the single shared datapath adder of the multiplier sequencer.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module add8 #(
  parameter int W = 8
) (
  output logic [W-1:0] sum,
  output logic         cout,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin
);

  logic [W:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (w_carry[i]),
      .s  (sum[i]),
      .co (w_carry[i+1])
    );
  end

  assign cout = w_carry[W];

endmodule

// File: rtl/shift_add_mul_seq.sv
// Unsigned W x W -> 2W multiplier: retires one multiplier bit per clock
// through a single shared adder, with a busy flag and one-cycle done pulse.
module shift_add_mul_seq
  import mul_seq_pkg::*;
#(
  parameter int W     = mul_seq_pkg::W,
  parameter int CNT_W = mul_seq_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t             r_state;
  logic [W-1:0]       r_mcand;
  logic [2*W-1:0]     r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*W-1:0]     r_product;

  logic [W-1:0]       w_y;
  logic [W-1:0]       w_sum;
  logic               w_cout;
  logic [2*W-1:0]     w_acc_next;

  // Multiplier sits in the low half of acc; its LSB gates the multiplicand.
  assign w_y        = r_acc[0] ? r_mcand : '0;
  assign w_acc_next = {w_cout, w_sum, r_acc[W-1:1]};

  add8 #(.W(W)) u_add (
    .sum  (w_sum),
    .cout (w_cout),
    .x    (r_acc[2*W-1:W]),
    .y    (w_y),
    .cin  (1'b0)
  );

  // NOTE: every register, state included, is cleared by the async reset so an
  // abandoned operation leaves no partial product or stale handshake behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, so acc/cnt/state update as one atomic step.
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_mcand <= a;
            r_acc   <= {{W{1'b0}}, b};
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_next;
          if (r_cnt == CNT_LAST) begin
            r_state   <= ST_DONE;
            r_product <= w_acc_next;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == ST_RUN);
  assign done    = (r_state == ST_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_shift_add_mul_seq.sv
// Directed bench for shift_add_mul_seq: a cycle-level reference model of the
// request/done protocol with plain a*b arithmetic, plus literal expectations.
module tb_shift_add_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_checks = 0;
  int n_errors = 0;

  shift_add_mul_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: -1 = no operation in flight, 0..7 = cycles into the
  // computation, 8 = result presented. Results come from plain a*b.
  int          m_phase = -1;
  logic [15:0] m_pend  = 16'h0;
  logic [15:0] m_prod  = 16'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= -1;
      m_prod  <= 16'h0;
    end else begin
      if ((m_phase < 0 || m_phase == 8) && start === 1'b1) begin
        m_phase <= 0;
        m_pend  <= 16'(a) * 16'(b);
      end else if (m_phase >= 0 && m_phase < 8) begin
        m_phase <= m_phase + 1;
      end else begin
        m_phase <= -1;
      end
      if (m_phase == 7) m_prod <= m_pend;
    end
  end

  always @(negedge clk) begin
    check("model_busy", 32'(busy), 32'(m_phase >= 0 && m_phase < 8));
    check("model_done", 32'(done), 32'(m_phase == 8));
    check("model_product", 32'(product), 32'(m_prod));
  end

  // Called at the first falling edge after an accept; returns at the falling
  // edge where done is seen (or the cycle budget runs out).
  task automatic wait_done(input string nm, input logic [15:0] exp, input bit inject);
    int lat    = 1;
    int busy_n = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
      if (inject && lat == 3) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
      end
      if (inject && lat == 5) start = 1'b0;
    end
    check({nm, "_latency"}, 32'(lat), 32'd9);
    check({nm, "_busy_cycles"}, 32'(busy_n), 32'd8);
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_product"}, 32'(product), 32'(exp));
  endtask

  task automatic run_op(input string nm, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [15:0] exp);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(negedge clk);
    start = 1'b0;
    wait_done(nm, exp, 1'b0);
  endtask

  task automatic count_done(input string nm, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check(nm, 32'(pulses), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("zero", 8'h00, 8'h00, 16'h0000);
    @(negedge clk);
    run_op("13x11", 8'd13, 8'd11, 16'h008F);
    @(negedge clk);
    run_op("ffxff", 8'hFF, 8'hFF, 16'hFE01);
    @(negedge clk);
    run_op("one_x_b7", 8'h01, 8'hB7, 16'h00B7);
    @(negedge clk);
    run_op("c5_x_one", 8'hC5, 8'h01, 16'h00C5);
    @(negedge clk);

    // Start during RUN must be ignored.
    start = 1'b1;
    a     = 8'd7;
    b     = 8'd6;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start", 16'd42, 1'b1);
    count_done("ignore_start_single_done", 12);

    // Asynchronous reset in the middle of RUN.
    start = 1'b1;
    a     = 8'h80;
    b     = 8'h02;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_done", 32'(done), 32'd0);
    check("midrun_reset_product", 32'(product), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_done("midrun_reset_no_done", 14);

    // Back-to-back with start held high and new operands presented in DONE.
    start = 1'b1;
    a     = 8'd3;
    b     = 8'd5;
    @(negedge clk);
    wait_done("b2b_first", 16'd15, 1'b0);
    a = 8'd10;
    b = 8'd10;
    @(negedge clk);
    check("b2b_no_gap", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("b2b_second", 16'd100, 1'b0);
    @(negedge clk);

    // Reset asserted while done is high.
    run_op("pre_done_reset", 8'd2, 8'd9, 16'd18);
    #2 rst_n = 1'b0;
    #1;
    check("done_reset_done", 32'(done), 32'd0);
    check("done_reset_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done("done_reset_no_done", 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
